// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter for the shared SDRAM port.
// Round-robin grant with a per-grant ack quota so a master holding cyc cannot starve the other.
module wshb_arbiter #(
    parameter int unsigned QUOTA = 16,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [31:0]   m0_dat_ms,
    input  logic [3:0]    m0_sel,
    output logic          m0_ack,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [31:0]   m1_dat_ms,
    input  logic [3:0]    m1_sel,
    output logic          m1_ack,
    output logic [31:0]   m_dat_sm,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [31:0]   s_dat_ms,
    output logic [3:0]    s_sel,
    input  logic [31:0]   s_dat_sm,
    input  logic          s_ack
);

    localparam int unsigned CW = $clog2(QUOTA + 1);
    localparam logic [CW-1:0] C_LAST = CW'(QUOTA - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(QUOTA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic [CW-1:0] r_cnt;

    logic          w_owner;
    logic          w_own_cyc;
    logic          w_oth_cyc;
    logic [CW-1:0] w_cnt_inc;

    assign w_owner   = (r_state == GNT1);
    assign w_own_cyc = w_owner ? m1_cyc : m0_cyc;
    assign w_oth_cyc = w_owner ? m0_cyc : m1_cyc;
    assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // on a tie, the master that was not served last wins
                    if (m0_cyc && (!m1_cyc || r_last)) begin
                        r_state <= GNT0;
                        r_cnt   <= '0;
                    end else if (m1_cyc) begin
                        r_state <= GNT1;
                        r_cnt   <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (s_ack)
                        r_cnt <= w_cnt_inc;
                    if (!w_own_cyc) begin
                        r_state <= IDLE;
                        r_last  <= w_owner;
                    end else if (s_ack && (r_cnt == C_LAST)) begin
                        if (w_oth_cyc) begin
                            r_state <= IDLE;
                            r_last  <= w_owner;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        case (r_state)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_ms = m0_dat_ms;
                s_sel    = m0_sel;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_ms = m1_dat_ms;
                s_sel    = m1_sel;
            end
            default: ;
        endcase
    end

    assign m0_ack   = s_ack & (r_state == GNT0);
    assign m1_ack   = s_ack & (r_state == GNT1);
    assign m_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter (QUOTA=4): table-driven cycles plus
// hand-written quota/reset sequences, with expected outputs queued per cycle.
module tb_wshb_arbiter;

    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we, m0_ack;
    logic [AW-1:0] m0_adr;
    logic [31:0]   m0_dat_ms;
    logic [3:0]    m0_sel;
    logic          m1_cyc, m1_stb, m1_we, m1_ack;
    logic [AW-1:0] m1_adr;
    logic [31:0]   m1_dat_ms;
    logic [3:0]    m1_sel;
    logic [31:0]   m_dat_sm;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0] s_adr;
    logic [31:0]   s_dat_ms, s_dat_sm;
    logic [3:0]    s_sel;

    int checks = 0;
    int errors = 0;

    wshb_arbiter #(.QUOTA(4), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack),
        .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_dat_sm(s_dat_sm), .s_ack(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // src: 0 = slave side idle, 1 = m0 routed, 2 = m1 routed
    typedef struct {
        logic       rst;
        logic       c0;
        logic       c1;
        logic       ack;
        logic [1:0] src;
        logic       a0;
        logic       a1;
    } vec_t;

    typedef struct {
        logic          cyc, stb, we, a0, a1;
        logic [AW-1:0] adr;
        logic [31:0]   dat, dsm;
        logic [3:0]    sel;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        rst_n     = v.rst;
        m0_cyc    = v.c0;
        m0_stb    = v.c0;
        m0_we     = 1'($urandom);
        m0_adr    = $urandom;
        m0_dat_ms = $urandom;
        m0_sel    = 4'($urandom);
        m1_cyc    = v.c1;
        m1_stb    = v.c1;
        m1_we     = 1'($urandom);
        m1_adr    = $urandom;
        m1_dat_ms = $urandom;
        m1_sel    = 4'($urandom);
        s_ack     = v.ack;
        s_dat_sm  = $urandom;
        e = '{cyc: 1'b0, stb: 1'b0, we: 1'b0, a0: v.a0, a1: v.a1,
              adr: '0, dat: '0, dsm: s_dat_sm, sel: '0};
        if (v.src == 2'd1) begin
            e.cyc = m0_cyc; e.stb = m0_stb; e.we = m0_we;
            e.adr = m0_adr; e.dat = m0_dat_ms; e.sel = m0_sel;
        end else if (v.src == 2'd2) begin
            e.cyc = m1_cyc; e.stb = m1_stb; e.we = m1_we;
            e.adr = m1_adr; e.dat = m1_dat_ms; e.sel = m1_sel;
        end
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("s_cyc",    32'(s_cyc),    32'(g.cyc));
        chk("s_stb",    32'(s_stb),    32'(g.stb));
        chk("s_we",     32'(s_we),     32'(g.we));
        chk("s_adr",    s_adr,         g.adr);
        chk("s_dat_ms", s_dat_ms,      g.dat);
        chk("s_sel",    32'(s_sel),    32'(g.sel));
        chk("m0_ack",   32'(m0_ack),   32'(g.a0));
        chk("m1_ack",   32'(m1_ack),   32'(g.a1));
        chk("m_dat_sm", m_dat_sm,      g.dsm);
    endtask

    task automatic st(input logic rst, input logic c0, input logic c1, input logic ack,
                      input logic [1:0] src, input logic a0, input logic a1);
        vec_t v;
        v = '{rst: rst, c0: c0, c1: c1, ack: ack, src: src, a0: a0, a1: a1};
        step(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0;
        s_ack = 0; s_dat_sm = '0;

        // reset: every output idle even with requests and a stray ack
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
        // m0 alone: grant, 5 acked writes, drop cyc, back to idle
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
        for (int unsigned i = 0; i < 5; i++)
            tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
        // simultaneous request after reset: m0 first, ack with cyc drop, idle, m1
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1});
        // quota release: m1 streams, m0 joins at ack 2, m1 still gets 4 acks
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1});
        for (int unsigned i = 0; i < 3; i++)
            tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1});

        foreach (tbl[i]) step(tbl[i]);

        // m1 alone for 20 acks: quota renews without any idle gap
        st(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        st(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 20; i++)
            st(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);

        // reset while m1 has a strobe pending, then m0 wins the tie
        st(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        st(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        st(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        st(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);

        // late quota ack with m0_cyc rising in the same cycle
        st(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        st(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 3; i++)
            st(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
        st(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        st(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        st(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
        st(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        st(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
